// File: rtl/alu_sequencer.sv
// Sequencer that runs one complete ALU operation over the ALU's bus port:
// latch A, B, op (and optionally F), compute, then read back Y and flags.
module alu_sequencer #(
   parameter int WORDSIZE = 16,
   parameter int CMD_W    = 4,
   parameter int TIMEOUT  = 8
) (
   input  logic                i_Clk,
   input  logic                i_Reset_n,
   input  logic                i_ReqValid,
   output logic                o_ReqReady,
   input  logic [WORDSIZE-1:0] i_A,
   input  logic [WORDSIZE-1:0] i_B,
   input  logic [3:0]          i_Op,
   input  logic                i_UseFlags,
   input  logic [7:0]          i_Flags,
   output logic                o_RespValid,
   input  logic                i_RespReady,
   output logic [WORDSIZE-1:0] o_Y,
   output logic [7:0]          o_Flags,
   output logic                o_Error,
   output logic [CMD_W-1:0]    o_BusCommand,
   output logic [WORDSIZE-1:0] o_BusData,
   output logic                o_BusValid,
   input  logic [WORDSIZE-1:0] i_BusData,
   input  logic                i_BusValid
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [CMD_W-1:0] COM_LATCHA  = CMD_W'(4'd0);
   localparam logic [CMD_W-1:0] COM_LATCHB  = CMD_W'(4'd1);
   localparam logic [CMD_W-1:0] COM_LATCHOP = CMD_W'(4'd2);
   localparam logic [CMD_W-1:0] COM_LATCHF  = CMD_W'(4'd3);
   localparam logic [CMD_W-1:0] COM_COMPUTE = CMD_W'(4'd4);
   localparam logic [CMD_W-1:0] COM_OUTPUTY = CMD_W'(4'd5);
   localparam logic [CMD_W-1:0] COM_OUTPUTF = CMD_W'(4'd6);

   typedef enum logic [3:0] {
      S_IDLE, S_LATCH_A, S_LATCH_B, S_LATCH_OP, S_LATCH_F,
      S_COMPUTE, S_READ_Y, S_READ_F, S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d, res_y_q, res_y_d;
   logic [3:0]          op_q, op_d;
   logic                use_flags_q, use_flags_d, err_q, err_d;
   logic [7:0]          flags_q, flags_d, res_flags_q, res_flags_d;
   logic                timeout_s;

   assign timeout_s = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state, operand capture and response capture
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      use_flags_d = use_flags_q;
      flags_d     = flags_q;
      res_y_d     = res_y_q;
      res_flags_d = res_flags_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (i_ReqValid) begin
               a_d         = i_A;
               b_d         = i_B;
               op_d        = i_Op;
               use_flags_d = i_UseFlags;
               flags_d     = i_Flags;
               err_d       = 1'b0;
               state_d     = S_LATCH_A;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LATCH_A:  state_d = S_LATCH_B;
         S_LATCH_B:  state_d = S_LATCH_OP;
         S_LATCH_OP: begin
            if (use_flags_q) begin
               state_d = S_LATCH_F;
            end else begin
               state_d = S_COMPUTE;
            end
         end
         S_LATCH_F:  state_d = S_COMPUTE;
         S_COMPUTE: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_READ_Y;
         end
         S_READ_Y: begin
            if (i_BusValid) begin
               res_y_d = i_BusData;
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_READ_F;
            end else if (timeout_s) begin
               // a Y timeout abandons the flags read entirely
               res_y_d     = {WORDSIZE{1'b0}};
               res_flags_d = 8'd0;
               err_d       = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1'b1);
            end
         end
         S_READ_F: begin
            if (i_BusValid) begin
               res_flags_d = i_BusData[7:0];
               state_d     = S_RESP;
            end else if (timeout_s) begin
               res_y_d     = {WORDSIZE{1'b0}};
               res_flags_d = 8'd0;
               err_d       = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1'b1);
            end
         end
         S_RESP: begin
            if (i_RespReady) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and data registers with synchronous active-low reset
   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         a_q         <= {WORDSIZE{1'b0}};
         b_q         <= {WORDSIZE{1'b0}};
         op_q        <= 4'd0;
         use_flags_q <= 1'b0;
         flags_q     <= 8'd0;
         res_y_q     <= {WORDSIZE{1'b0}};
         res_flags_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         use_flags_q <= use_flags_d;
         flags_q     <= flags_d;
         res_y_q     <= res_y_d;
         res_flags_q <= res_flags_d;
         err_q       <= err_d;
      end
   end

   // Bus drive decoded from registered state; LATCHA with valid low is the ALU no-op
   always_comb begin
      o_BusCommand = COM_LATCHA;
      o_BusData    = {WORDSIZE{1'b0}};
      o_BusValid   = 1'b0;
      case (state_q)
         S_LATCH_A: begin
            o_BusCommand = COM_LATCHA;
            o_BusData    = a_q;
            o_BusValid   = 1'b1;
         end
         S_LATCH_B: begin
            o_BusCommand = COM_LATCHB;
            o_BusData    = b_q;
            o_BusValid   = 1'b1;
         end
         S_LATCH_OP: begin
            o_BusCommand = COM_LATCHOP;
            o_BusData    = {{(WORDSIZE-4){1'b0}}, op_q};
            o_BusValid   = 1'b1;
         end
         S_LATCH_F: begin
            o_BusCommand = COM_LATCHF;
            o_BusData    = {{(WORDSIZE-8){1'b0}}, flags_q};
            o_BusValid   = 1'b1;
         end
         S_COMPUTE: o_BusCommand = COM_COMPUTE;
         S_READ_Y:  o_BusCommand = COM_OUTPUTY;
         S_READ_F:  o_BusCommand = COM_OUTPUTF;
         default:   o_BusCommand = COM_LATCHA;
      endcase
   end

   assign o_ReqReady  = (state_q == S_IDLE);
   assign o_RespValid = (state_q == S_RESP);
   assign o_Y         = res_y_q;
   assign o_Flags     = res_flags_q;
   assign o_Error     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU sits on the bus, and a reference
// model predicts bus traces, latency and response for directed and random ops.
module tb_alu_sequencer;

   localparam int TIMEOUT = 8;
   localparam logic [3:0] COM_LATCHA = 4'd0, COM_LATCHB = 4'd1, COM_LATCHOP = 4'd2,
                          COM_LATCHF = 4'd3, COM_COMPUTE = 4'd4, COM_OUTPUTY = 4'd5,
                          COM_OUTPUTF = 4'd6;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_ADC = 4'd1, ALU_SUB = 4'd2, ALU_SBB = 4'd3,
                          ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6;
   localparam int F_CARRY = 0, F_ZERO = 1;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, use_flags = 1'b0;
   logic [15:0] a = 16'd0, b = 16'd0, y;
   logic [3:0]  op = 4'd0, bus_cmd;
   logic [7:0]  flags_in = 8'd0, flags_out;
   logic        resp_valid, resp_ready = 1'b0, err;
   logic [15:0] bus_data_o, bus_data_i;
   logic        bus_valid_o, bus_valid_i;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WORDSIZE(16), .CMD_W(4), .TIMEOUT(TIMEOUT)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n),
      .i_ReqValid(req_valid), .o_ReqReady(req_ready),
      .i_A(a), .i_B(b), .i_Op(op), .i_UseFlags(use_flags), .i_Flags(flags_in),
      .o_RespValid(resp_valid), .i_RespReady(resp_ready),
      .o_Y(y), .o_Flags(flags_out), .o_Error(err),
      .o_BusCommand(bus_cmd), .o_BusData(bus_data_o), .o_BusValid(bus_valid_o),
      .i_BusData(bus_data_i), .i_BusValid(bus_valid_i)
   );

   // ALU arithmetic: returns {flags, y}
   function automatic logic [23:0] alu_fn(input logic [3:0] f_op, input logic [15:0] fa,
                                          input logic [15:0] fb, input logic [7:0] fin);
      logic [16:0] s;
      logic [7:0]  f;
      case (f_op)
         ALU_ADD: s = {1'b0, fa} + {1'b0, fb};
         ALU_ADC: s = {1'b0, fa} + {1'b0, fb} + {16'd0, fin[F_CARRY]};
         ALU_SUB: s = {1'b0, fa} - {1'b0, fb};
         ALU_SBB: s = {1'b0, fa} - {1'b0, fb} - {16'd0, fin[F_CARRY]};
         ALU_AND: s = {1'b0, fa & fb};
         ALU_OR:  s = {1'b0, fa | fb};
         ALU_XOR: s = {1'b0, fa ^ fb};
         default: s = {1'b0, fa};
      endcase
      f          = 8'd0;
      f[F_CARRY] = s[16];
      f[F_ZERO]  = (s[15:0] == 16'd0);
      return {f, s[15:0]};
   endfunction

   // Behavioural ALU on the bus; reads answer combinationally unless withheld
   logic [15:0] m_a = 16'd0, m_b = 16'd0, m_y = 16'd0;
   logic [3:0]  m_op = 4'd0;
   logic [7:0]  m_f = 8'd0;
   int          compute_cnt = 0;
   bit          hold_y = 1'b0, hold_f = 1'b0;

   always @(posedge clk) begin
      if (bus_valid_o) begin
         case (bus_cmd)
            COM_LATCHA:  m_a  <= bus_data_o;
            COM_LATCHB:  m_b  <= bus_data_o;
            COM_LATCHOP: m_op <= bus_data_o[3:0];
            COM_LATCHF:  m_f  <= bus_data_o[7:0];
            default: ;
         endcase
      end
      if (bus_cmd == COM_COMPUTE) begin
         {m_f, m_y}  <= alu_fn(m_op, m_a, m_b, m_f);
         compute_cnt <= compute_cnt + 1;
      end
   end

   always_comb begin
      bus_valid_i = 1'b0;
      bus_data_i  = 16'h0000;
      if (bus_cmd == COM_OUTPUTY) begin
         bus_valid_i = !hold_y;
         bus_data_i  = m_y;
      end else if (bus_cmd == COM_OUTPUTF) begin
         bus_valid_i = !hold_f;
         bus_data_i  = {8'hA5, m_f};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"},  32'(req_ready),   32'd1);
      check({tag, "_resp_valid"}, 32'(resp_valid),  32'd0);
      check({tag, "_y"},          32'(y),           32'd0);
      check({tag, "_flags"},      32'(flags_out),   32'd0);
      check({tag, "_err"},        32'(err),         32'd0);
      check({tag, "_bus_cmd"},    32'(bus_cmd),     32'(COM_LATCHA));
      check({tag, "_bus_valid"},  32'(bus_valid_o), 32'd0);
      check({tag, "_bus_data"},   32'(bus_data_o),  32'd0);
   endtask

   // ALU rF as the reference sees it (flags left by the last compute or preload)
   logic [7:0] ref_f = 8'd0;

   // mode 0: normal, 1: withhold Y, 2: withhold F
   task automatic do_op(input logic [3:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                        input bit uf, input logic [7:0] fl, input int mode, input int hold,
                        output int lat, output logic [15:0] y_o, output logic [7:0] f_o);
      logic [3:0]  ecmd[$];
      bit          evld[$];
      logic [15:0] edat[$];
      logic [23:0] res;
      logic [15:0] exp_y;
      logic [7:0]  exp_f;
      logic [24:0] snap;
      int          mism;
      res   = alu_fn(op_v, a_v, b_v, uf ? fl : ref_f);
      ref_f = res[23:16];
      exp_y = (mode != 0) ? 16'd0 : res[15:0];
      exp_f = (mode != 0) ? 8'd0 : res[23:16];
      ecmd.push_back(COM_LATCHA);  evld.push_back(1'b1); edat.push_back(a_v);
      ecmd.push_back(COM_LATCHB);  evld.push_back(1'b1); edat.push_back(b_v);
      ecmd.push_back(COM_LATCHOP); evld.push_back(1'b1); edat.push_back({12'd0, op_v});
      if (uf) begin
         ecmd.push_back(COM_LATCHF); evld.push_back(1'b1); edat.push_back({8'd0, fl});
      end
      ecmd.push_back(COM_COMPUTE); evld.push_back(1'b0); edat.push_back(16'd0);
      for (int i = 0; i < ((mode == 1) ? TIMEOUT : 1); i++) begin
         ecmd.push_back(COM_OUTPUTY); evld.push_back(1'b0); edat.push_back(16'd0);
      end
      if (mode != 1) begin
         for (int i = 0; i < ((mode == 2) ? TIMEOUT : 1); i++) begin
            ecmd.push_back(COM_OUTPUTF); evld.push_back(1'b0); edat.push_back(16'd0);
         end
      end
      hold_y = (mode == 1);
      hold_f = (mode == 2);

      @(negedge clk);
      check("req_ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; a = a_v; b = b_v; op = op_v; use_flags = uf; flags_in = fl;
      @(posedge clk);
      #1;
      req_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      use_flags = 1'($urandom); flags_in = 8'($urandom);
      mism = 0;
      lat  = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = c;
            break;
         end
         if (c - 1 >= ecmd.size()) begin
            mism++;
         end else if (bus_cmd !== ecmd[c-1] || bus_valid_o !== evld[c-1] ||
                      (evld[c-1] && bus_data_o !== edat[c-1])) begin
            mism++;
         end
      end
      check("bus_trace", 32'(mism), 32'd0);
      check("latency", 32'(lat), 32'(ecmd.size() + 1));
      check("resp_y", 32'(y), 32'(exp_y));
      check("resp_flags", 32'(flags_out), 32'(exp_f));
      check("resp_err", 32'(err), (mode != 0) ? 32'd1 : 32'd0);
      y_o  = y;
      f_o  = flags_out;
      snap = {y, flags_out, err};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_outputs", 32'({y, flags_out, err}), 32'(snap));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_resp_valid", 32'(resp_valid), 32'd1);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("post_handshake_ready", 32'({req_ready, resp_valid}), 32'b10);
      hold_y = 1'b0;
      hold_f = 1'b0;
   endtask

   initial begin
      int          lat, cc, r, md;
      logic [15:0] yo;
      logic [7:0]  fo;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("after_release");

      do_op(ALU_ADD, 16'h1234, 16'h0001, 1'b0, 8'h00, 0, 0, lat, yo, fo);
      check("add_latency7", 32'(lat), 32'd7);
      check("add_y", 32'(yo), 32'h1235);
      check("add_cz", 32'(fo[1:0]), 32'd0);

      do_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 0, 1, lat, yo, fo);
      check("wrap_y", 32'(yo), 32'h0000);
      check("wrap_cz", 32'({fo[F_CARRY], fo[F_ZERO]}), 32'b11);

      do_op(ALU_ADC, 16'h0001, 16'h0001, 1'b1, 8'h01, 0, 0, lat, yo, fo);
      check("adc_y", 32'(yo), 32'h0003);
      check("adc_latency8", 32'(lat), 32'd8);

      do_op(ALU_ADD, 16'h00F0, 16'h000F, 1'b0, 8'h00, 1, 2, lat, yo, fo);
      check("timeout_latency", 32'(lat), 32'(4 + TIMEOUT + 1));
      do_op(ALU_XOR, 16'hAAAA, 16'h5555, 1'b0, 8'h00, 0, 0, lat, yo, fo);
      do_op(ALU_SUB, 16'h0003, 16'h0005, 1'b0, 8'h00, 0, 5, lat, yo, fo);
      do_op(ALU_OR, 16'h0F00, 16'h00F0, 1'b1, 8'h02, 2, 1, lat, yo, fo);

      // reset while LATCH_B is on the bus
      cc = compute_cnt;
      @(negedge clk);
      req_valid = 1'b1; a = 16'h4321; b = 16'h1111; op = ALU_ADD; use_flags = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_latchb", 32'(bus_cmd), 32'(COM_LATCHB));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("mid_op_reset");
      repeat (10) @(negedge clk);
      check("no_compute_after_reset", 32'(compute_cnt), 32'(cc));
      do_op(ALU_SBB, 16'h0010, 16'h0001, 1'b1, 8'h01, 0, 0, lat, yo, fo);
      check("sbb_y", 32'(yo), 32'h000E);

      for (int n = 0; n < 20; n++) begin
         r  = $urandom_range(0, 9);
         md = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
         do_op(4'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), 1'($urandom),
               8'($urandom), md, $urandom_range(0, 3), lat, yo, fo);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
